uart_rx_cfg: RTL and testbench
==============================

# uart_rx_cfg

Configurable UART receiver, the parametrised successor to the fixed 8N1 receiver. It samples a serial line using an external oversampling tick (`s_tick`, from the baud generator). Data width, oversampling rate, parity mode and stop length are all parameters. It adds an input synchroniser, majority-vote bit sampling, false-start rejection, parity/framing/break error reporting, and a stable output data register. It sits between the pin and the RX FIFO or consumer logic, in the same place as the current receiver.

## Interface
- `DBIT`, 8: data bits per frame; legal range 5..9; sent LSB first.
- `OVS`, 16: `s_tick` pulses per bit period; must be even and at least 8.
- `PARITY`, 0: 0 = none, 1 = even, 2 = odd.
- `SB_TICK`, 16: `s_tick` count spent in the stop state (16/24/32 gives 1/1.5/2 stop bits at OVS=16); must be at least OVS/2+2.
- `clk` input 1: system clock.
- `reset_n` input 1: reset, asynchronous and active-low.
- `rx` input 1: raw serial line; idles high.
- `s_tick` input 1: one-clk oversampling enable.
- `rx_done_tick` output 1: one-clk pulse when a frame completes, whether or not it has errors.
- `rx_dout` output DBIT: last received data word; updated only when a frame completes.
- `parity_err` output 1: parity mismatch in the last frame; always 0 when PARITY=0.
- `frame_err` output 1: first stop-bit sample of the last frame was 0.
- `break_det` output 1: last frame was all zeros through the stop bit.

## Operation
- `rx` passes through a 2-FF synchroniser; both flops reset to 1. All logic below uses `rx_s`, the synchronised value.
- Counters:
  - `s` (bit-period tick counter) is sized for max(OVS, SB_TICK)-1.
  - `n` (data-bit index) is sized for DBIT-1.
  - Both advance only on `s_tick`.
- Sampling: each bit takes 3 samples, on `s_tick` with s = OVS/2-1, OVS/2 and OVS/2+1. The bit value is the majority of the 3 (2 of 3 wins).
- FSM states: idle, start, data, par, stop, recover.
  - idle: when `rx_s`=0, set s=0 and go to start. `s_tick` is not needed for this transition.
  - start: vote as above. At s=OVS/2+1, if the vote is 1 it is a false start: go to idle with no pulse and no flag change. Otherwise continue to s=OVS-1, then set s=0, n=0 and go to data.
  - data: vote each bit and shift the voted bit into the MSB of the shift register (right shift, LSB first). At s=OVS-1: if n=DBIT-1, go to par (PARITY≠0) or stop; otherwise increment n. In both cases set s=0.
  - par: vote the parity bit. At s=OVS-1, set s=0 and go to stop.
  - stop: vote the first stop bit. At s=SB_TICK-1, complete the frame:
    - copy the shift register to `rx_dout`;
    - update all flags;
    - pulse `rx_done_tick`;
    - go to recover if the stop vote was 0 and `rx_s`=0, otherwise go to idle.
  - recover: wait until `rx_s`=1, then go to idle. This stops a held-low line (break) from retriggering frames.
- Parity check: XOR of the DBIT data bits and the parity bit must be 0 for even parity and 1 for odd parity. Otherwise set `parity_err`.
- `break_det` = `frame_err` AND all data bits 0 AND (PARITY=0 OR the parity sample was 0).
- Flags and `rx_dout` keep their values until the next frame completes. A false start does not change them.

## Timing
- Reset values: `rx_done_tick`=0, `rx_dout`=0, `parity_err`=0, `frame_err`=0, `break_det`=0. FSM resets to idle, s=0, n=0, shift register 0, synchroniser 11.
- Reset asserted mid-frame aborts the frame immediately. No pulse is produced and the outputs take their reset values.
- `rx_done_tick`, `rx_dout` and the flags are registered and all update on the same clk edge: the edge following the `s_tick` cycle that completes stop. The pulse is high for exactly 1 clk.
- Latency from the `rx` falling edge to `rx` being seen in idle is 2 clk (synchroniser).
- Frame length from the detected falling edge to `rx_done_tick` is (1+DBIT+(PARITY≠0))·OVS + SB_TICK `s_tick`s, plus 1 clk.
- If `s_tick` is held high every clk, this still works; counts are in clocks.

## Test plan
- OVS=16, PARITY=0, `s_tick` every 4 clk, send 0xA5 in 8N1 → one `rx_done_tick`, `rx_dout`=0xA5, all flags 0. `rx_dout` is unchanged during the frame.
- PARITY=1, send 0x03 with parity bit 0 then 0x03 with parity bit 1 → first frame `parity_err`=0, second `parity_err`=1 with `rx_dout`=0x03.
- 1-`s_tick` glitch on a data bit at s=OVS/2, and 8-`s_tick` low pulse on an idle line → data unaffected; the low pulse gives a false start: no pulse, flags unchanged.
- Stop bit driven 0, then line high → `frame_err`=1, `break_det`=0 for data 0x55; FSM returns to idle.
- Line held low for 3 frame times → exactly one `rx_done_tick` with `rx_dout`=0x00, `frame_err`=1, `break_det`=1. A next frame received after the line returns high decodes correctly.
- `reset_n` pulsed low during data bit 4 → all outputs 0 and no pulse. A following frame of 0x3C decodes correctly.

Source files
------------

// File: rtl/uart_rx_cfg_if.sv
// Signal bundle between the serial pin side and the UART receiver outputs.
// The master modport is the receiver; the slave modport is the line driver and consumer.
interface uart_rx_cfg_if #(
  parameter int DBIT = 8
);
  logic            rx;
  logic            s_tick;
  logic            rx_done_tick;
  logic [DBIT-1:0] rx_dout;
  logic            parity_err;
  logic            frame_err;
  logic            break_det;

  modport master (
    input  rx, s_tick,
    output rx_done_tick, rx_dout, parity_err, frame_err, break_det
  );

  modport slave (
    output rx, s_tick,
    input  rx_done_tick, rx_dout, parity_err, frame_err, break_det
  );
endinterface

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: synchronised input, 3-sample majority vote per bit,
// false-start rejection, parity/framing/break reporting and a held output word.
module uart_rx_cfg #(
  parameter int DBIT    = 8,
  parameter int OVS     = 16,
  parameter int PARITY  = 0,
  parameter int SB_TICK = 16
) (
  input logic           clk,
  input logic           reset_n,
  uart_rx_cfg_if.master bus
);

  localparam int SMAX = (OVS > SB_TICK) ? OVS : SB_TICK;
  localparam int SW   = $clog2(SMAX);
  localparam int NW   = $clog2(DBIT);

  localparam logic [SW-1:0] S_V0   = SW'(OVS/2 - 1);
  localparam logic [SW-1:0] S_V1   = SW'(OVS/2);
  localparam logic [SW-1:0] S_V2   = SW'(OVS/2 + 1);
  localparam logic [SW-1:0] S_BEND = SW'(OVS - 1);
  localparam logic [SW-1:0] S_SEND = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PAR,
    ST_STOP,
    ST_RECOVER
  } state_t;

  state_t          state, state_n;
  logic [SW-1:0]   s, s_n;
  logic [NW-1:0]   n, n_n;
  logic [DBIT-1:0] b, b_n;
  logic            v0, v0_n, v1, v1_n;
  logic            par_q, par_n;
  logic            stp_q, stp_n;
  logic            sync1, rx_s;
  logic            maj, stop_bit;
  logic            done_n, pe_n, fe_n, bd_n;
  logic [DBIT-1:0] dout_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= bus.rx;
      rx_s  <= sync1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= ST_IDLE;
      s                <= '0;
      n                <= '0;
      b                <= '0;
      v0               <= 1'b0;
      v1               <= 1'b0;
      par_q            <= 1'b0;
      stp_q            <= 1'b0;
      bus.rx_done_tick <= 1'b0;
      bus.rx_dout      <= '0;
      bus.parity_err   <= 1'b0;
      bus.frame_err    <= 1'b0;
      bus.break_det    <= 1'b0;
    end else begin
      state            <= state_n;
      s                <= s_n;
      n                <= n_n;
      b                <= b_n;
      v0               <= v0_n;
      v1               <= v1_n;
      par_q            <= par_n;
      stp_q            <= stp_n;
      bus.rx_done_tick <= done_n;
      bus.rx_dout      <= dout_n;
      bus.parity_err   <= pe_n;
      bus.frame_err    <= fe_n;
      bus.break_det    <= bd_n;
    end
  end

  // Third sample is the live line value; the first two were latched on earlier ticks.
  assign maj      = (v0 & v1) | (v0 & rx_s) | (v1 & rx_s);
  // With SB_TICK = OVS/2+2 the stop vote and frame completion land on the same tick.
  assign stop_bit = (s == S_V2) ? maj : stp_q;

  always_comb begin
    state_n = state;
    s_n     = s;
    n_n     = n;
    b_n     = b;
    v0_n    = v0;
    v1_n    = v1;
    par_n   = par_q;
    stp_n   = stp_q;
    done_n  = 1'b0;
    dout_n  = bus.rx_dout;
    pe_n    = bus.parity_err;
    fe_n    = bus.frame_err;
    bd_n    = bus.break_det;

    if (bus.s_tick && state != ST_IDLE && state != ST_RECOVER) begin
      if (s == S_V0) v0_n = rx_s;
      if (s == S_V1) v1_n = rx_s;
    end

    unique case (state)
      ST_IDLE: begin
        if (!rx_s) begin
          s_n     = '0;
          state_n = ST_START;
        end
      end
      ST_START: begin
        if (bus.s_tick) begin
          if (s == S_V2 && maj) begin
            state_n = ST_IDLE;
          end else if (s == S_BEND) begin
            s_n     = '0;
            n_n     = '0;
            state_n = ST_DATA;
          end else begin
            s_n = s + 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (bus.s_tick) begin
          if (s == S_V2) b_n = {maj, b[DBIT-1:1]};
          if (s == S_BEND) begin
            s_n = '0;
            if (n == N_LAST) state_n = (PARITY != 0) ? ST_PAR : ST_STOP;
            else             n_n     = n + 1'b1;
          end else begin
            s_n = s + 1'b1;
          end
        end
      end
      ST_PAR: begin
        if (bus.s_tick) begin
          if (s == S_V2) par_n = maj;
          if (s == S_BEND) begin
            s_n     = '0;
            state_n = ST_STOP;
          end else begin
            s_n = s + 1'b1;
          end
        end
      end
      ST_STOP: begin
        if (bus.s_tick) begin
          if (s == S_V2) stp_n = maj;
          if (s == S_SEND) begin
            s_n    = '0;
            done_n = 1'b1;
            dout_n = b;
            pe_n   = (PARITY == 0) ? 1'b0 : ((^b ^ par_q) ^ (PARITY == 2));
            fe_n   = !stop_bit;
            bd_n   = !stop_bit && (b == '0) && (PARITY == 0 || !par_q);
            state_n = (!stop_bit && !rx_s) ? ST_RECOVER : ST_IDLE;
          end else begin
            s_n = s + 1'b1;
          end
        end
      end
      ST_RECOVER: begin
        if (rx_s) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench: two receivers (no parity, even parity) driven with directed frames.
module tb_uart_rx_cfg;

  localparam int BIT = 64;  // 16 ticks per bit, one tick every 4 clk

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
    logic       bd;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic rx0 = 1'b1;
  logic rx1 = 1'b1;
  logic tick = 1'b0;
  int unsigned tick_cnt = 0;
  int checks = 0;
  int errors = 0;
  exp_t q0[$];
  exp_t q1[$];

  uart_rx_cfg_if #(.DBIT(8)) if0 ();
  uart_rx_cfg_if #(.DBIT(8)) if1 ();

  assign if0.rx     = rx0;
  assign if1.rx     = rx1;
  assign if0.s_tick = tick;
  assign if1.s_tick = tick;

  uart_rx_cfg #(.DBIT(8), .OVS(16), .PARITY(0), .SB_TICK(16)) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(if0.master));
  uart_rx_cfg #(.DBIT(8), .OVS(16), .PARITY(1), .SB_TICK(16)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(if1.master));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    tick_cnt <= (tick_cnt == 3) ? 0 : tick_cnt + 1;
    tick     <= (tick_cnt == 2);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input int idx, input logic v, input int nclk);
    if (idx == 0) rx0 = v;
    else          rx1 = v;
    repeat (nclk) @(negedge clk);
  endtask

  task automatic send_frame(input int idx, input logic [7:0] d, input bit has_par,
                            input logic pb, input logic stop, input int gbit);
    drive(idx, 1'b0, BIT);
    for (int i = 0; i < 8; i++) begin
      if (i == gbit) begin
        drive(idx, d[i], 30);
        drive(idx, !d[i], 4);
        drive(idx, d[i], 30);
      end else begin
        drive(idx, d[i], BIT);
      end
    end
    if (has_par) drive(idx, pb, BIT);
    drive(idx, stop, BIT);
    drive(idx, 1'b1, BIT);
  endtask

  task automatic chk_outs0(input string tag, input exp_t e);
    chk({tag, "_dout"}, int'(if0.rx_dout), int'(e.d));
    chk({tag, "_pe"}, int'(if0.parity_err), int'(e.pe));
    chk({tag, "_fe"}, int'(if0.frame_err), int'(e.fe));
    chk({tag, "_bd"}, int'(if0.break_det), int'(e.bd));
  endtask

  // Monitors: pop one expectation per completion pulse.
  always @(negedge clk) begin
    exp_t e;
    if (if0.rx_done_tick) begin
      if (q0.size() == 0) begin
        chk("unexpected_pulse0", 1, 0);
      end else begin
        e = q0.pop_front();
        chk_outs0("frame0", e);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (if1.rx_done_tick) begin
      if (q1.size() == 0) begin
        chk("unexpected_pulse1", 1, 0);
      end else begin
        e = q1.pop_front();
        chk("frame1_dout", int'(if1.rx_dout), int'(e.d));
        chk("frame1_pe", int'(if1.parity_err), int'(e.pe));
        chk("frame1_fe", int'(if1.frame_err), int'(e.fe));
        chk("frame1_bd", int'(if1.break_det), int'(e.bd));
      end
    end
  end

  initial begin
    repeat (5) @(negedge clk);
    chk_outs0("reset", '{d: 8'h00, pe: 1'b0, fe: 1'b0, bd: 1'b0});
    chk("reset_done0", int'(if0.rx_done_tick), 0);
    chk("reset_dout1", int'(if1.rx_dout), 0);
    reset_n = 1'b1;
    repeat (BIT) @(negedge clk);

    // Even parity: 0x03 has two ones, so parity bit 0 is correct and 1 is wrong.
    q1.push_back('{d: 8'h03, pe: 1'b0, fe: 1'b0, bd: 1'b0});
    send_frame(1, 8'h03, 1'b1, 1'b0, 1'b1, -1);
    q1.push_back('{d: 8'h03, pe: 1'b1, fe: 1'b0, bd: 1'b0});
    send_frame(1, 8'h03, 1'b1, 1'b1, 1'b1, -1);

    q0.push_back('{d: 8'hA5, pe: 1'b0, fe: 1'b0, bd: 1'b0});
    fork
      send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1, -1);
      begin
        repeat (5 * BIT) @(negedge clk);
        chk("dout_hold", int'(if0.rx_dout), 0);
      end
    join

    // One-tick glitch inside data bit 1 must be outvoted.
    q0.push_back('{d: 8'h5A, pe: 1'b0, fe: 1'b0, bd: 1'b0});
    send_frame(0, 8'h5A, 1'b0, 1'b0, 1'b1, 1);

    // 8-tick low pulse: false start, nothing changes.
    drive(0, 1'b0, 32);
    drive(0, 1'b1, 3 * BIT);
    chk_outs0("false_start", '{d: 8'h5A, pe: 1'b0, fe: 1'b0, bd: 1'b0});

    q0.push_back('{d: 8'h55, pe: 1'b0, fe: 1'b1, bd: 1'b0});
    send_frame(0, 8'h55, 1'b0, 1'b0, 1'b0, -1);

    q0.push_back('{d: 8'h3A, pe: 1'b0, fe: 1'b0, bd: 1'b0});
    send_frame(0, 8'h3A, 1'b0, 1'b0, 1'b1, -1);

    // Break: line low for three frame times yields a single flagged frame.
    q0.push_back('{d: 8'h00, pe: 1'b0, fe: 1'b1, bd: 1'b1});
    drive(0, 1'b0, 3 * 10 * BIT);
    drive(0, 1'b1, 2 * BIT);
    q0.push_back('{d: 8'hC3, pe: 1'b0, fe: 1'b0, bd: 1'b0});
    send_frame(0, 8'hC3, 1'b0, 1'b0, 1'b1, -1);

    // Reset in the middle of data bit 4 aborts the frame.
    drive(0, 1'b0, BIT);
    for (int i = 0; i < 4; i++) drive(0, 1'b1, BIT);
    drive(0, 1'b1, 32);
    reset_n = 1'b0;
    #1;
    chk_outs0("mid_reset", '{d: 8'h00, pe: 1'b0, fe: 1'b0, bd: 1'b0});
    chk("mid_reset_done", int'(if0.rx_done_tick), 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    drive(0, 1'b1, 10 * BIT);
    chk_outs0("post_reset", '{d: 8'h00, pe: 1'b0, fe: 1'b0, bd: 1'b0});

    q0.push_back('{d: 8'h3C, pe: 1'b0, fe: 1'b0, bd: 1'b0});
    send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1, -1);

    repeat (4 * BIT) @(negedge clk);
    chk("pending0", q0.size(), 0);
    chk("pending1", q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
